tick_generator: RTL and testbench
=================================

Name: tick_generator

Overview:
- Parametrised successor to the one-second enable divider.
- Base prescaler with a runtime-reloadable period. Reload uses shadow-register semantics and takes effect at wrap.
- Clock enable, synchronous clear, and NUM_CH cascaded sub-dividers. Each sub-divider gives a 1-cycle tick and a 50% square wave, e.g. the 1 s step tick and the 2 Hz amber blink of the traffic-light controller.

Parameters:
- CNT_W, 25, width of the base counter and of period_in.
- DEFAULT_PERIOD, 26_999_999, terminal count after reset. Base period = value+1 clk cycles.
- NUM_CH, 2, number of cascaded sub-divider channels.
- SUB_W, 4, width of each channel counter and each channel divisor field.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  count enable; when low, all counters hold.
- clear  in  1  synchronous clear, 1-cycle pulse or level.
- period_in  in  CNT_W  new base terminal count.
- period_load  in  1  1-cycle strobe that captures period_in.
- ch_div  in  NUM_CH*SUB_W  per-channel terminal count; channel i occupies bits [i*SUB_W +: SUB_W].
- base_tick  out  1  1-cycle pulse every period+1 enabled cycles.
- ch_tick  out  NUM_CH  1-cycle pulse every ch_div[i]+1 base ticks.
- ch_wave  out  NUM_CH  toggles on each ch_tick[i].
- period_pending  out  1  a loaded period is waiting for the next wrap.

Behaviour:
- Reset (reset_n low, asynchronous):
  - count=0, period_reg=DEFAULT_PERIOD, shadow=DEFAULT_PERIOD, all ch_cnt=0.
  - base_tick=0, ch_tick=0, ch_wave=0, period_pending=0.
- Base counter: all outputs are registered. With enable=1 and clear=0:
  - If count==period_reg, the edge sets count←0 and base_tick←1.
  - Otherwise count←count+1 and base_tick←0.
  - base_tick is therefore high for exactly one cycle per period_reg+1 enabled cycles.
  - period_reg=0 gives base_tick continuously high.
- enable=0: count, ch_cnt and ch_wave hold; base_tick and ch_tick are forced to 0 on the next edge. period_load is still accepted.
- Period reload:
  - period_load=1 sets shadow←period_in and period_pending←1.
  - At the next wrap edge: period_reg←shadow and period_pending←0.
  - period_load on the same edge as a wrap: period_in goes straight to period_reg and period_pending=0.
  - Back-to-back loads: the last value wins.
  - The counter never runs past a shorter new period, because the new period is applied only at wrap from count=0.
- clear=1 (priority over wrap and enable):
  - count←0, all ch_cnt←0, ch_wave←0, base_tick←0, ch_tick←0.
  - A pending shadow is applied immediately (period_reg←shadow, pending←0).
  - A simultaneous period_load applies period_in directly.
- Channel i advances only on an edge where the base wrap occurs:
  - If ch_cnt[i] >= ch_div[i], then ch_cnt[i]←0, ch_tick[i]←1 and ch_wave[i] toggles.
  - Otherwise ch_cnt[i]←ch_cnt[i]+1 and ch_tick[i]←0.
  - ch_tick[i] is coincident with the base_tick that completes the channel period.
  - The >= compare guarantees that lowering ch_div mid-count wraps at the next base tick rather than after 2^SUB_W ticks.
  - ch_div is sampled live and is not registered.
- Arithmetic: all counters are unsigned and wrap only through the terminal compare. There is no overflow path because period_reg ≤ 2^CNT_W−1.
- Reset asserted mid-period: all state returns to reset values immediately. Counting restarts from 0 on the first edge after reset_n rises.

Decomposition:
- Shared package/include:
  - CNT_W and SUB_W defaults.
  - DEFAULT_PERIOD for synthesis (26_999_999).
  - Simulation period constant (3).
  - Channel index constants CH_STEP=0 and CH_BLINK=1.
- One sub-module, tick_subdivider (ports: clk, reset_n, clear, enable, tick_in, div, tick_out, wave), instantiated NUM_CH times in a generate loop.
- The base prescaler and reload logic stay in tick_generator.

Test Plan:
- Reset then steady count: DEFAULT_PERIOD=3, enable=1, ch_div={1,3}.
  - base_tick pulses at edges 4, 8, 12, …
  - ch_tick[0] pulses every 16 cycles; ch_tick[1] every 8 cycles.
  - ch_wave[1] has a 16-cycle period.
- Reload mid-period: at count=1 load period_in=5.
  - period_pending=1 until the wrap at count=3.
  - Following base_ticks are 6 cycles apart; pending drops at the wrap edge.
- Simultaneous load and wrap: period_load with period_in=1 on the wrap edge.
  - pending stays 0; the next base_tick arrives 2 cycles later.
- Enable gating: drop enable for 5 cycles at count=2.
  - No ticks during the gap; count resumes from 2 and the next tick is delayed exactly 5 cycles.
- Clear with pending load: load 7, then clear 2 cycles later.
  - count=0, ch_wave=0, pending=0.
  - The next base_tick arrives 8 cycles after clear is released.
- Async reset mid-operation and period 0:
  - reset_n low between edges zeroes outputs immediately.
  - After release with period_in=0 loaded, base_tick stays continuously high, and ch_div=0 gives ch_tick continuously high.

Source files
------------

// File: rtl/tick_generator_pkg.sv
// tick_generator_pkg: shared widths, periods and channel indices for the tick generator.
package tick_generator_pkg;
  localparam int CNT_W_DEF  = 25;
  localparam int SUB_W_DEF  = 4;
  localparam int NUM_CH_DEF = 2;
  localparam int unsigned PERIOD_SYN = 26_999_999;
  localparam int unsigned PERIOD_SIM = 3;
  localparam int CH_STEP  = 0;
  localparam int CH_BLINK = 1;
endpackage

// File: rtl/tick_subdivider.sv
// tick_subdivider: divides an incoming tick stream into a 1-cycle tick and a 50% square wave.
module tick_subdivider
  import tick_generator_pkg::*;
#(
  parameter int SUB_W = SUB_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             tick_in,
  input  logic [SUB_W-1:0] div,
  output logic             tick_out,
  output logic             wave
);
  logic [SUB_W-1:0] cnt;
  logic hit, term;
  assign hit  = enable && tick_in;
  // >= so a divisor lowered mid-count wraps on the next input tick
  assign term = cnt >= div;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt      <= '0;
      tick_out <= 1'b0;
      wave     <= 1'b0;
    end else if (clear) begin
      cnt      <= '0;
      tick_out <= 1'b0;
      wave     <= 1'b0;
    end else begin
      tick_out <= hit && term;
      if (hit) begin
        cnt  <= term ? '0 : cnt + SUB_W'(1);
        wave <= wave ^ term;
      end
    end
endmodule

// File: rtl/tick_generator.sv
// tick_generator: reloadable base prescaler feeding NUM_CH cascaded tick/wave sub-dividers.
module tick_generator
  import tick_generator_pkg::*;
#(
  parameter int          CNT_W          = CNT_W_DEF,
  parameter int unsigned DEFAULT_PERIOD = PERIOD_SYN,
  parameter int          NUM_CH         = NUM_CH_DEF,
  parameter int          SUB_W          = SUB_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [CNT_W-1:0]        period_in,
  input  logic                    period_load,
  input  logic [NUM_CH*SUB_W-1:0] ch_div,
  output logic                    base_tick,
  output logic [NUM_CH-1:0]       ch_tick,
  output logic [NUM_CH-1:0]       ch_wave,
  output logic                    period_pending
);
  logic [CNT_W-1:0] count, period_reg, shadow, next_period;
  logic wrap;
  assign wrap = enable && !clear && count == period_reg;
  // a load coinciding with a wrap or clear bypasses the shadow
  assign next_period = period_load ? period_in : shadow;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count          <= '0;
      period_reg     <= CNT_W'(DEFAULT_PERIOD);
      shadow         <= CNT_W'(DEFAULT_PERIOD);
      base_tick      <= 1'b0;
      period_pending <= 1'b0;
    end else if (clear) begin
      count          <= '0;
      base_tick      <= 1'b0;
      period_reg     <= next_period;
      shadow         <= next_period;
      period_pending <= 1'b0;
    end else begin
      if (enable) count <= wrap ? '0 : count + CNT_W'(1);
      base_tick <= wrap;
      if (period_load) shadow <= period_in;
      if (wrap) period_reg <= next_period;
      period_pending <= !wrap && (period_load || period_pending);
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_subdivider #(.SUB_W(SUB_W)) u_sub (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .enable   (enable),
      .tick_in  (wrap),
      .div      (ch_div[i*SUB_W +: SUB_W]),
      .tick_out (ch_tick[i]),
      .wave     (ch_wave[i])
    );
  end
endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: directed scoreboard bench for tick_generator with a 4-cycle base period.
module tb_tick_generator;
  import tick_generator_pkg::*;
  localparam int CNT_W = 25;
  localparam int SUB_W = 4;
  logic clk = 1'b0;
  logic reset_n, enable, clear, period_load;
  logic [CNT_W-1:0] period_in;
  logic [2*SUB_W-1:0] ch_div;
  logic base_tick, period_pending;
  logic [1:0] ch_tick, ch_wave;
  typedef struct {string tag; logic [31:0] exp;} sb_t;
  sb_t sb[$];
  int compared = 0;
  int mismatched = 0;

  tick_generator #(
    .CNT_W(CNT_W), .DEFAULT_PERIOD(PERIOD_SIM), .NUM_CH(2), .SUB_W(SUB_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .period_in(period_in), .period_load(period_load), .ch_div(ch_div),
    .base_tick(base_tick), .ch_tick(ch_tick), .ch_wave(ch_wave),
    .period_pending(period_pending)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    do begin
      tick1();
      n++;
    end while (!base_tick && n < maxc);
    if (!base_tick) n = -1;
  endtask

  initial begin
    int n, gap;
    reset_n = 1'b1; enable = 1'b1; clear = 1'b0; period_load = 1'b0; period_in = '0;
    ch_div = '0;
    ch_div[CH_STEP*SUB_W +: SUB_W]  = 4'd3;
    ch_div[CH_BLINK*SUB_W +: SUB_W] = 4'd1;
    #2 reset_n = 1'b0;
    #10;
    push("reset_outputs", 32'd0);
    check({base_tick, ch_tick, ch_wave, period_pending});
    @(posedge clk); #1 reset_n = 1'b1;
    // steady count: base every 4, blink every 8, step every 16 cycles
    for (int k = 1; k <= 32; k++) begin
      tick1();
      push($sformatf("steady_k%0d", k),
           {27'd0, k % 4 == 0, k % 8 == 0, k % 16 == 0, 1'((k / 8) % 2), 1'((k / 16) % 2)});
      check({base_tick, ch_tick[1], ch_tick[0], ch_wave[1], ch_wave[0]});
    end
    // reload mid-period at count=1
    tick1();
    period_in = 25'd5; period_load = 1'b1;
    tick1();
    period_load = 1'b0;
    push("reload_pending_set", 32'd1); check(period_pending);
    tick1();
    push("reload_pending_hold", 32'd1); check(period_pending);
    tick1();
    push("reload_wrap", 32'd2); check({base_tick, period_pending});
    wait_tick(20, n); push("reload_gap1", 32'd6); check(n);
    wait_tick(20, n); push("reload_gap2", 32'd6); check(n);
    // load on the wrap edge
    repeat (5) tick1();
    period_in = 25'd1; period_load = 1'b1;
    tick1();
    period_load = 1'b0;
    push("load_on_wrap", 32'd2); check({base_tick, period_pending});
    wait_tick(20, n); push("load_on_wrap_gap", 32'd2); check(n);
    // back to period 3, then gate enable at count=2
    period_in = 25'd3; period_load = 1'b1;
    tick1();
    period_load = 1'b0;
    tick1();
    push("restore_wrap", 32'd1); check(base_tick);
    repeat (2) tick1();
    enable = 1'b0;
    gap = 0;
    for (int k = 0; k < 5; k++) begin
      tick1();
      gap++;
      push($sformatf("gated_%0d", k), 32'd0); check({base_tick, ch_tick});
    end
    enable = 1'b1;
    wait_tick(20, n); push("gated_delay", 32'd7); check(gap + n);
    // clear with a pending load
    period_in = 25'd7; period_load = 1'b1;
    tick1();
    period_load = 1'b0;
    push("clear_pre_pending", 32'd1); check(period_pending);
    tick1();
    clear = 1'b1;
    tick1();
    clear = 1'b0;
    push("clear_state", 32'd0); check({base_tick, ch_tick, ch_wave, period_pending});
    wait_tick(30, n); push("clear_gap", 32'd8); check(n);
    // async reset between edges
    #2 reset_n = 1'b0;
    #1 push("async_reset", 32'd0); check({base_tick, ch_tick, ch_wave, period_pending});
    ch_div = '0; period_in = '0;
    tick1();
    reset_n = 1'b1; period_load = 1'b1;
    tick1();
    period_load = 1'b0;
    wait_tick(20, n); push("zero_first", 32'd3); check(n);
    for (int k = 0; k < 6; k++) begin
      tick1();
      push($sformatf("zero_cont_%0d", k), 32'd7); check({base_tick, ch_tick});
    end
    push("scoreboard_drained", 32'd0); check(sb.size() - 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
